// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_arbiter_pkg
// Description : Shared types, arbiter state encoding and helpers for the
//               write-back stage (wb_arbiter / wb_fifo).
//               Register-file widths normally come from the core-wide defines
//               file; the fallbacks below keep this slice self-contained.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif

package wb_arbiter_pkg;

  typedef logic [`RegAddrBus] reg_addr_t;
  typedef logic [`RegBus]     reg_data_t;

  // One GPR write-port transaction.
  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } wb_write_t;

  // Arbiter states: NORMAL lets EX win, FORCE drains one FIFO entry.
  localparam logic [0:0] C_ARB_NORMAL = 1'b0;
  localparam logic [0:0] C_ARB_FORCE  = 1'b1;

  // A result reaches the GPR file only if it is still live and not x0.
  function automatic logic gpr_writable(input logic live, input reg_addr_t rd);
    return live && (rd != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Load-result buffer for the write-back stage. Each of the
//               DEPTH slots holds {live, rd, data}. A live bit is cleared on
//               pop or when a newer EX write to the same rd kills the slot.
//               Two rd match vectors feed the decode hazard check.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push_i/push_rd_i/push_data_i - write a new live entry
//               pop_i               - retire the head entry
//               kill_i/kill_rd_i    - mark live entries with rd == kill_rd_i dead
//               query1_i/query2_i   - rd values to match against live entries
//               empty_o/full_o      - occupancy flags
//               head_live_o/head_rd_o/head_data_o - head entry contents
//               match1_o/match2_o   - per-slot live-entry rd match vectors
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [`RegAddrBus] push_rd_i,
  input  logic [`RegBus]     push_data_i,
  input  logic               pop_i,
  input  logic               kill_i,
  input  logic [`RegAddrBus] kill_rd_i,
  input  logic [`RegAddrBus] query1_i,
  input  logic [`RegAddrBus] query2_i,
  output logic               empty_o,
  output logic               full_o,
  output logic               head_live_o,
  output logic [`RegAddrBus] head_rd_o,
  output logic [`RegBus]     head_data_o,
  output logic [DEPTH-1:0]   match1_o,
  output logic [DEPTH-1:0]   match2_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [DEPTH-1:0] r_live;
  reg_addr_t        r_rd   [DEPTH];
  reg_data_t        r_data [DEPTH];

  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  logic [DEPTH-1:0] w_kill_hit;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);

  assign head_live_o = r_live[w_ridx];
  assign head_rd_o   = r_rd[w_ridx];
  assign head_data_o = r_data[w_ridx];

  // Unoccupied slots always have live=0, so the live bit alone qualifies a slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign match1_o[gi]   = r_live[gi] && (r_rd[gi] == query1_i);
    assign match2_o[gi]   = r_live[gi] && (r_rd[gi] == query2_i);
    assign w_kill_hit[gi] = kill_i && r_live[gi] && (r_rd[gi] == kill_rd_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + (AW+1)'(1);
      if (pop_i)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // The push slot is never occupied, so a same-cycle kill cannot hit the
  // entry being written: a load pushed alongside an EX result stays live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (w_widx == AW'(i))) begin
          r_live[i] <= 1'b1;
        end else if ((pop_i && (w_ridx == AW'(i))) || w_kill_hit[i]) begin
          r_live[i] <= 1'b0;
        end
      end
    end
  end

  // Payload needs no reset: it is only consumed through a live slot.
  always_ff @(posedge clk) begin
    if (push_i) begin
      r_rd[w_widx]   <= push_rd_i;
      r_data[w_widx] <= push_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Write-back stage. Merges single-cycle EX results (priority)
//               and buffered LSU load results onto the registered GPR write
//               port, with anti-starvation forcing of the load FIFO, WAW
//               kill of stale loads and a decode read-hazard flag.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               ex_valid_i/ex_ready_o/ex_rd_i/ex_data_i     - EX result handshake
//               lsu_valid_i/lsu_ready_o/lsu_rd_i/lsu_data_i - load result handshake
//               raddr1_i/raddr2_i/hazard_o      - decode hazard query
//               we_o/waddr_o/wdata_o            - GPR write port (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [`RegAddrBus] ex_rd_i,
  input  logic [`RegBus]     ex_data_i,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic [`RegAddrBus] lsu_rd_i,
  input  logic [`RegBus]     lsu_data_i,
  input  logic [`RegAddrBus] raddr1_i,
  input  logic [`RegAddrBus] raddr2_i,
  output logic               hazard_o,
  output logic               we_o,
  output logic [`RegAddrBus] waddr_o,
  output logic [`RegBus]     wdata_o
);

  localparam int              SW            = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   C_STARVE_LAST = SW'(STARVE_MAX - 1);
  localparam logic [SW-1:0]   C_STARVE_MAX  = SW'(STARVE_MAX);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [SW-1:0]    r_starve;
  logic [SW-1:0]    w_starve_next;
  logic             r_ex_ready;
  logic             r_we;
  reg_addr_t        r_waddr;
  reg_data_t        r_wdata;

  logic             w_ex_accept;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic             w_head_live;
  reg_addr_t        w_head_rd;
  reg_data_t        w_head_data;
  logic [DEPTH-1:0] w_match1;
  logic [DEPTH-1:0] w_match2;
  logic             w_haz1;
  logic             w_haz2;
  wb_write_t        w_wr;

  // --------------------------------------------------------------------------
  // Load FIFO
  // --------------------------------------------------------------------------
  assign w_push      = lsu_valid_i && !w_full;
  assign lsu_ready_o = !w_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_rd_i   (lsu_rd_i),
    .push_data_i (lsu_data_i),
    .pop_i       (w_pop),
    .kill_i      (w_ex_accept),
    .kill_rd_i   (ex_rd_i),
    .query1_i    (raddr1_i),
    .query2_i    (raddr2_i),
    .empty_o     (w_empty),
    .full_o      (w_full),
    .head_live_o (w_head_live),
    .head_rd_o   (w_head_rd),
    .head_data_o (w_head_data),
    .match1_o    (w_match1),
    .match2_o    (w_match2)
  );

  // --------------------------------------------------------------------------
  // Arbiter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_ARB_NORMAL;
    else        r_state <= w_state_next;
  end

  // FORCE is entered on the edge where the starve count reaches STARVE_MAX.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_ARB_NORMAL: begin
        if (w_ex_accept && !w_empty && (r_starve == C_STARVE_LAST))
          w_state_next = C_ARB_FORCE;
      end
      C_ARB_FORCE:  w_state_next = C_ARB_NORMAL;
      default:      w_state_next = C_ARB_NORMAL;
    endcase
  end

  always_comb begin
    w_ex_accept = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      C_ARB_NORMAL: begin
        w_ex_accept = ex_valid_i;
        w_pop       = !ex_valid_i && !w_empty;
      end
      C_ARB_FORCE:  w_pop = !w_empty;
      default:      w_pop = 1'b0;
    endcase
  end

  // ex_ready_o is a flop so EX sees a clean, glitch-free stall in FORCE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex_ready <= 1'b1;
    else        r_ex_ready <= (w_state_next == C_ARB_NORMAL);
  end
  assign ex_ready_o = r_ex_ready;

  // --------------------------------------------------------------------------
  // Starve counter: consecutive EX wins while loads are waiting
  // --------------------------------------------------------------------------
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty)
      w_starve_next = '0;
    else if (w_ex_accept && (r_starve != C_STARVE_MAX))
      w_starve_next = r_starve + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else        r_starve <= w_starve_next;
  end

  // --------------------------------------------------------------------------
  // Write-port select and output register
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr.we   = 1'b0;
    w_wr.addr = ex_rd_i;
    w_wr.data = ex_data_i;
    if (w_ex_accept) begin
      w_wr.we   = gpr_writable(1'b1, ex_rd_i);
    end else if (w_pop) begin
      // Dead (superseded) entries and x0 loads retire without writing.
      w_wr.we   = gpr_writable(w_head_live, w_head_rd);
      w_wr.addr = w_head_rd;
      w_wr.data = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr.we;
      if (w_wr.we) begin
        r_waddr <= w_wr.addr;
        r_wdata <= w_wr.data;
      end
    end
  end

  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;

  // --------------------------------------------------------------------------
  // Read hazard: live buffered loads plus the write currently on the port,
  // since the GPR read is combinational and still returns the old value.
  // --------------------------------------------------------------------------
  assign w_haz1   = (raddr1_i != '0) && ((|w_match1) || (r_we && (r_waddr == raddr1_i)));
  assign w_haz2   = (raddr2_i != '0) && ((|w_match2) || (r_we && (r_waddr == raddr2_i)));
  assign hazard_o = w_haz1 || w_haz2;

`ifndef SYNTHESIS
`ifndef RV32I_BASE_ISA
  // Reduced register file: only x0..x15 exist.
  a_ex_rd_range: assert property (@(posedge clk) disable iff (!rst_n)
    ex_valid_i |-> !ex_rd_i[4]);
  a_lsu_rd_range: assert property (@(posedge clk) disable iff (!rst_n)
    lsu_valid_i |-> !lsu_rd_i[4]);
`endif
`endif

endmodule

`default_nettype wire
